cv32e40p_cnn_bitserial_acc: RTL and testbench

//  Sequential, parametrised bit-plane combiner for the CNN datapath. Accepts one bit-plane of
//  per-lane partial sums per cycle (LSB plane first) and shift-accumulates it over N planes.
//  In signed mode the MSB plane carries negative weight. Returns LANES full-width results over
//  a valid/ready handshake. Sits between the bit-AND multiply array and the M_cnn_Cache writeback.

---
 rtl/cv32e40p_cnn_pkg.sv | 31 +++
 rtl/cv32e40p_cnn_bitserial_acc_if.sv | 33 +++
 rtl/cv32e40p_cnn_bs_lane.sv | 57 +++++
 rtl/cv32e40p_cnn_bitserial_acc.sv | 149 ++++++++++++++
 tb/tb_cv32e40p_cnn_bitserial_acc.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_cnn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cv32e40p_cnn_pkg
// Brief    : Shared types, default sizes and helpers for the bit-serial
//            CNN plane accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package cv32e40p_cnn_pkg;

  localparam int DEF_LANES    = 16;
  localparam int DEF_PSUM_W   = 16;
  localparam int DEF_ACT_BITS = 8;
  localparam int DEF_OUT_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic signed [DEF_PSUM_W-1:0] psum_t;
  typedef logic signed [DEF_OUT_W-1:0]  result_t;

  // A requested precision of 0 or above the maximum means "full precision".
  function automatic int unsigned eff_nbits(input int unsigned n, input int unsigned max_n);
    return ((n == 0) || (n > max_n)) ? max_n : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_cnn_bitserial_acc_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cv32e40p_cnn_bitserial_acc_if
// Brief    : Plane input channel and result output channel, each a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface cv32e40p_cnn_bitserial_acc_if #(
  parameter int LANES  = 16,
  parameter int PSUM_W = 16,
  parameter int OUT_W  = 32
);
  logic                          plane_valid_i;
  logic                          plane_ready_o;
  logic [LANES-1:0][PSUM_W-1:0]  plane_i;
  logic                          res_valid_o;
  logic                          res_ready_i;
  logic [LANES-1:0][OUT_W-1:0]   res_o;

  // Producer/consumer side of the accumulator
  modport master (
    output plane_valid_i, plane_i, res_ready_i,
    input  plane_ready_o, res_valid_o, res_o
  );

  // Accumulator side
  modport slave (
    input  plane_valid_i, plane_i, res_ready_i,
    output plane_ready_o, res_valid_o, res_o
  );
endinterface
`default_nettype wire

// File: rtl/cv32e40p_cnn_bs_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cv32e40p_cnn_bs_lane
// Brief    : One lane accumulator: sign-extends a plane partial sum, shifts
//            it by the plane index, optionally negates it and adds it in.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_cnn_bs_lane #(
  parameter int PSUM_W = 16,
  parameter int OUT_W  = 32,
  parameter int K_W    = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [PSUM_W-1:0] plane_i,
  input  wire logic [K_W-1:0]    k_i,
  input  wire logic              negate_i,
  input  wire logic              load_i,
  input  wire logic              en_i,
  input  wire logic              clr_i,
  output logic      [OUT_W-1:0]  acc_o
);

  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_d;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_shift;
  logic [OUT_W-1:0] w_term;

  assign w_sext  = {{(OUT_W-PSUM_W){plane_i[PSUM_W-1]}}, plane_i};
  assign w_shift = w_sext << k_i;
  assign w_term  = negate_i ? (~w_shift + {{(OUT_W-1){1'b0}}, 1'b1}) : w_shift;

  // Next accumulator value: clear wins, first plane loads, later planes add.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = load_i ? w_term : (acc_q + w_term);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_cnn_bitserial_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cv32e40p_cnn_bitserial_acc
// Brief    : Bit-plane combiner. Shift-accumulates LSB-first bit-planes of
//            per-lane partial sums into LANES full-width results, with
//            runtime precision, signed mode, backpressure and abort.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_cnn_bitserial_acc
  import cv32e40p_cnn_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int PSUM_W   = DEF_PSUM_W,
  parameter int ACT_BITS = DEF_ACT_BITS,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        mode_i,
  input  wire logic                        signed_i,
  input  wire logic [$clog2(ACT_BITS):0]   nbits_i,
  input  wire logic                        flush_i,
  cv32e40p_cnn_bitserial_acc_if.slave      bus
);

  localparam int NB_W = $clog2(ACT_BITS) + 1;

  if (OUT_W < PSUM_W + ACT_BITS + 1) begin : g_width_err
    $error("cv32e40p_cnn_bitserial_acc: OUT_W too small for PSUM_W+ACT_BITS+1");
  end

  state_e                      state_q;
  logic [NB_W-1:0]             k_q;
  logic [NB_W-1:0]             effn_q;
  logic                        mode_q;
  logic                        signed_q;
  logic                        ready_q;
  logic                        rvalid_q;

  logic                        w_fire;
  logic                        w_pop;
  logic [NB_W-1:0]             w_effn_in;
  logic                        w_last;
  logic                        w_neg;
  logic [NB_W-1:0]             w_k;
  logic                        w_load;
  logic                        w_clr;
  logic [LANES-1:0][OUT_W-1:0] w_acc;

  // Flush blocks the plane presented in the same cycle.
  assign w_fire    = bus.plane_valid_i && ready_q && !flush_i;
  assign w_pop     = rvalid_q && bus.res_ready_i;
  assign w_effn_in = NB_W'(eff_nbits(32'(nbits_i), ACT_BITS));

  // In IDLE the config comes straight from the inputs; later it is latched.
  assign w_last = (state_q == IDLE) ? (w_effn_in == NB_W'(1))
                                    : (k_q == (effn_q - NB_W'(1)));
  assign w_neg  = ((state_q == IDLE) ? signed_i : signed_q) && w_last;
  assign w_k    = (state_q == IDLE) ? '0 : k_q;
  assign w_load = (state_q == IDLE);
  assign w_clr  = flush_i || w_pop;

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      effn_q   <= '0;
      mode_q   <= 1'b0;
      signed_q <= 1'b0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      k_q      <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (w_fire) begin
            mode_q   <= mode_i;
            signed_q <= signed_i;
            effn_q   <= w_effn_in;
            k_q      <= NB_W'(1);
            if (w_last) begin
              state_q  <= DONE;
              ready_q  <= 1'b0;
              rvalid_q <= 1'b1;
            end else begin
              state_q  <= ACC;
            end
          end
        end
        ACC: begin
          if (w_fire) begin
            k_q <= k_q + NB_W'(1);
            if (w_last) begin
              state_q  <= DONE;
              ready_q  <= 1'b0;
              rvalid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          k_q      <= '0;
          ready_q  <= 1'b1;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cv32e40p_cnn_bs_lane #(
      .PSUM_W (PSUM_W),
      .OUT_W  (OUT_W),
      .K_W    (NB_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .plane_i  (bus.plane_i[g]),
      .k_i      (w_k),
      .negate_i (w_neg),
      .load_i   (w_load),
      .en_i     (w_fire),
      .clr_i    (w_clr),
      .acc_o    (w_acc[g])
    );
  end

  assign bus.plane_ready_o = ready_q;
  assign bus.res_valid_o   = rvalid_q;
  // Results are only exposed while pending, and zeroed when CNN mode is off.
  assign bus.res_o         = (rvalid_q && mode_q) ? w_acc : '0;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_cnn_bitserial_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_cnn_bitserial_acc
// Brief    : Self-checking bench: directed vector table, multi-cycle corner
//            sequences and randomized operations against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_cnn_bitserial_acc;

  localparam int L   = 16;
  localparam int PW  = 16;
  localparam int AB  = 8;
  localparam int OW  = 32;
  localparam int NBW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode_i = 1'b0;
  logic           signed_i = 1'b0;
  logic [NBW-1:0] nbits_i = '0;
  logic           flush_i = 1'b0;

  always #5 clk = ~clk;

  cv32e40p_cnn_bitserial_acc_if #(.LANES(L), .PSUM_W(PW), .OUT_W(OW)) bus();

  cv32e40p_cnn_bitserial_acc #(
    .LANES(L), .PSUM_W(PW), .ACT_BITS(AB), .OUT_W(OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode_i   (mode_i),
    .signed_i (signed_i),
    .nbits_i  (nbits_i),
    .flush_i  (flush_i),
    .bus      (bus)
  );

  typedef struct {
    bit             md;
    bit             sg;
    logic [3:0]     nb;
    int             lane;
    logic [7:0][15:0] pl;
    logic [31:0]    exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic signed [PW-1:0] cur_pl [AB][L];
  logic [OW-1:0]        res_cap [L];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int eff_of(input logic [NBW-1:0] nb);
    return ((nb == 0) || (int'(nb) > AB)) ? AB : int'(nb);
  endfunction

  // Reference: sum of plane[k] * 2^k, top plane subtracted in signed mode.
  function automatic logic [OW-1:0] model(input bit md, input bit sg, input int eff, input int lane);
    longint s = 0;
    longint t;
    for (int k = 0; k < eff; k++) begin
      t = longint'(cur_pl[k][lane]) * (longint'(1) << k);
      if (sg && (k == eff - 1)) s = s - t;
      else                      s = s + t;
    end
    return md ? s[OW-1:0] : '0;
  endfunction

  task automatic clr_planes();
    for (int k = 0; k < AB; k++)
      for (int l = 0; l < L; l++)
        cur_pl[k][l] = '0;
  endtask

  task automatic drive_plane(input int k);
    for (int l = 0; l < L; l++) bus.plane_i[l] = cur_pl[k][l];
  endtask

  // Streams one operation from cur_pl with valid held high; optionally pops.
  task automatic run_op(input bit md, input bit sg, input logic [NBW-1:0] nb,
                        input int pop_delay, input bit do_pop);
    int  eff;
    int  stalls;
    int  w;
    bit  early;
    bit  diff;
    eff = eff_of(nb);
    mode_i = md; signed_i = sg; nbits_i = nb;
    stalls = 0; early = 1'b0;
    for (int k = 0; k < eff; k++) begin
      drive_plane(k);
      bus.plane_valid_i = 1'b1;
      w = 0;
      while (!bus.plane_ready_o && w < 20) begin
        @(posedge clk); #1; w++;
      end
      if (w >= 20) begin
        chk("plane_ready_timeout", 64'(0), 64'(1));
        bus.plane_valid_i = 1'b0;
        return;
      end
      if (k > 0) stalls += w;
      @(posedge clk); #1;
      if (k == 0) begin
        mode_i = 1'($urandom); signed_i = 1'($urandom); nbits_i = NBW'($urandom);
      end
      if ((k < eff - 1) && bus.res_valid_o) early = 1'b1;
    end
    bus.plane_valid_i = 1'b0;
    chk("early_done", 64'(early), 64'(0));
    chk("throughput_stalls", 64'(stalls), 64'(0));
    chk("latency_valid", 64'(bus.res_valid_o), 64'(1));
    chk("done_ready_low", 64'(bus.plane_ready_o), 64'(0));
    for (int l = 0; l < L; l++) res_cap[l] = bus.res_o[l];
    for (int d = 0; d < pop_delay; d++) begin
      bus.plane_valid_i = 1'b1;
      for (int l = 0; l < L; l++) bus.plane_i[l] = PW'($urandom);
      bus.res_ready_i = 1'b0;
      @(posedge clk); #1;
      diff = 1'b0;
      for (int l = 0; l < L; l++) if (bus.res_o[l] !== res_cap[l]) diff = 1'b1;
      chk("hold_valid", 64'(bus.res_valid_o), 64'(1));
      chk("hold_stable", 64'(diff), 64'(0));
      chk("hold_ready_low", 64'(bus.plane_ready_o), 64'(0));
    end
    bus.plane_valid_i = 1'b0;
    if (do_pop) begin
      bus.res_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.res_ready_i = 1'b0;
      chk("pop_valid_low", 64'(bus.res_valid_o), 64'(0));
      chk("pop_ready_high", 64'(bus.plane_ready_o), 64'(1));
    end
  endtask

  task automatic chk_lanes(input string nm, input int lane, input logic [OW-1:0] exp);
    for (int l = 0; l < L; l++)
      chk(nm, 64'(res_cap[l]), 64'((l == lane) ? exp : '0));
  endtask

  vec_t vecs [10];
  bit   md_r, sg_r;
  logic [NBW-1:0] nb_r;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'd8,  0,  {8{16'd1}},                          32'd255};
    vecs[1] = '{1'b1, 1'b1, 4'd8,  0,  {8{16'd1}},                          32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 1'b1, 4'd8,  1,  {8{16'h8000}},                       32'd32768};
    vecs[3] = '{1'b1, 1'b1, 4'd4,  3,  {{4{16'd0}}, 16'd1, 16'd0, 16'd0, 16'd3}, 32'hFFFF_FFFB};
    vecs[4] = '{1'b1, 1'b1, 4'd1,  2,  {{7{16'd0}}, 16'd7},                 32'hFFFF_FFF9};
    vecs[5] = '{1'b0, 1'b0, 4'd8,  0,  {8{16'd1}},                          32'd0};
    vecs[6] = '{1'b1, 1'b0, 4'd0,  5,  {8{16'd1}},                          32'd255};
    vecs[7] = '{1'b1, 1'b0, 4'd15, 4,  {8{16'd2}},                          32'd510};
    vecs[8] = '{1'b1, 1'b0, 4'd2,  0,  {{6{16'd0}}, 16'd1, 16'd1},          32'd3};
    vecs[9] = '{1'b1, 1'b1, 4'd3,  15, {{5{16'd0}}, {3{16'd1}}},            32'hFFFF_FFFF};

    bus.plane_valid_i = 1'b0;
    bus.res_ready_i   = 1'b0;
    bus.plane_i       = '0;
    clr_planes();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(bus.plane_ready_o), 64'(0));
    chk("reset_valid", 64'(bus.res_valid_o), 64'(0));
    chk("reset_res", 64'(|bus.res_o), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      clr_planes();
      for (int k = 0; k < AB; k++) cur_pl[k][vecs[v].lane] = vecs[v].pl[k];
      run_op(vecs[v].md, vecs[v].sg, vecs[v].nb, 0, 1'b1);
      chk_lanes($sformatf("vec%0d_res", v), vecs[v].lane, vecs[v].exp);
    end

    // Backpressure for 5 cycles, then a back-to-back op after the pop
    clr_planes();
    for (int k = 0; k < AB; k++) cur_pl[k][0] = 16'd1;
    run_op(1'b1, 1'b0, 4'd8, 5, 1'b1);
    chk_lanes("bp_res", 0, 32'd255);
    clr_planes();
    cur_pl[0][7] = 16'd1; cur_pl[1][7] = 16'd1;
    run_op(1'b1, 1'b0, 4'd2, 0, 1'b1);
    chk_lanes("b2b_res", 7, 32'd3);

    // Flush after 3 of 8 planes, then a clean op with no residue
    clr_planes();
    for (int k = 0; k < AB; k++) for (int l = 0; l < L; l++) cur_pl[k][l] = 16'h7FFF;
    mode_i = 1'b1; signed_i = 1'b1; nbits_i = 4'd8;
    for (int k = 0; k < 3; k++) begin
      drive_plane(k);
      bus.plane_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    bus.plane_valid_i = 1'b0;
    chk("flush_valid_low", 64'(bus.res_valid_o), 64'(0));
    chk("flush_ready_high", 64'(bus.plane_ready_o), 64'(1));
    clr_planes();
    cur_pl[0][0] = 16'd1; cur_pl[1][0] = 16'd1;
    run_op(1'b1, 1'b0, 4'd2, 0, 1'b1);
    chk_lanes("post_flush_res", 0, 32'd3);

    // Flush while a result is pending drops it
    clr_planes();
    cur_pl[0][2] = 16'd9;
    run_op(1'b1, 1'b0, 4'd1, 0, 1'b0);
    chk("pending_res", 64'(bus.res_o[2]), 64'(9));
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_done_valid", 64'(bus.res_valid_o), 64'(0));
    chk("flush_done_res", 64'(|bus.res_o), 64'(0));

    // Asynchronous reset with a pending result clears outputs without a clock
    clr_planes();
    cur_pl[0][1] = 16'd5; cur_pl[1][1] = 16'd5;
    run_op(1'b1, 1'b0, 4'd2, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.res_valid_o), 64'(0));
    chk("async_rst_ready", 64'(bus.plane_ready_o), 64'(0));
    chk("async_rst_res", 64'(|bus.res_o), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clr_planes();
    cur_pl[0][0] = 16'd1; cur_pl[1][0] = 16'd1;
    run_op(1'b1, 1'b0, 4'd2, 0, 1'b1);
    chk_lanes("post_rst_res", 0, 32'd3);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      md_r = ($urandom % 4) != 0;
      sg_r = 1'($urandom);
      nb_r = NBW'($urandom);
      for (int k = 0; k < AB; k++)
        for (int l = 0; l < L; l++)
          cur_pl[k][l] = PW'($urandom);
      run_op(md_r, sg_r, nb_r, int'($urandom % 3), 1'b1);
      for (int l = 0; l < L; l++)
        chk($sformatf("rand%0d_lane%0d", i, l), 64'(res_cap[l]),
            64'(model(md_r, sg_r, eff_of(nb_r), l)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
